// File: rtl/uart_stopwatch_host_pkg.sv
// Shared definitions for the UART stopwatch host: ASCII command/reply codes,
// FSM state encodings and the default baud divider.
package uart_stopwatch_host_pkg;
    localparam logic [7:0] ASCII_CLEAR = 8'h43;
    localparam logic [7:0] ASCII_GO    = 8'h47;
    localparam logic [7:0] ASCII_STOP  = 8'h53;
    localparam logic [7:0] ASCII_READ  = 8'h52;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SEND_CMD = 3'd1;
    localparam logic [2:0] ST_RX_D3    = 3'd2;
    localparam logic [2:0] ST_RX_D2    = 3'd3;
    localparam logic [2:0] ST_RX_DOT   = 3'd4;
    localparam logic [2:0] ST_RX_D1    = 3'd5;
    localparam logic [2:0] ST_RX_D0    = 3'd6;

    localparam int DEFAULT_BAUD_DIV = 163;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_ZERO + 8'd9);
    endfunction
endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver; samples mid-bit using a 16x oversampling tick.
module uart_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    output logic       rx_done_tick,
    output logic [7:0] dout
);
    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        rx_done_tick = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx) begin
                    state_d = S_START;
                    s_d     = '0;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (s_q == 4'd7) begin
                        state_d = S_DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (s_q == 4'd15) begin
                        s_d = '0;
                        b_d = {rx, b_q[7:1]};
                        if (n_q == 3'd7) state_d = S_STOP;
                        else             n_d = n_q + 3'd1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                if (s_tick) begin
                    if (s_q == 4'd15) begin
                        state_d      = S_IDLE;
                        rx_done_tick = 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
        endcase
    end

    assign dout = b_q;
endmodule

// File: rtl/uart_stopwatch_host_baud.sv
// 16x oversampling baud tick: one-cycle tick every BAUD_DIV+1 clocks.
module baud_tick_gen
    import uart_stopwatch_host_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (BAUD_DIV < 1) ? 1 : $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(BAUD_DIV);

    logic [CW-1:0] count_q, count_d;

    assign tick = (count_q == DIV_LAST);

    always_comb begin
        count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter driven by a 16x oversampling tick; tx is registered.
module uart_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic       s_tick,
    input  logic [7:0] din,
    output logic       tx_done_tick,
    output logic       tx
);
    localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [7:0] b_q, b_d;
    logic       tx_q, tx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        tx_d         = tx_q;
        tx_done_tick = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tx_start) begin
                    state_d = S_START;
                    s_d     = '0;
                    b_d     = din;
                end
            end
            S_START: begin
                tx_d = 1'b0;
                if (s_tick) begin
                    if (s_q == 4'd15) begin
                        state_d = S_DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            S_DATA: begin
                tx_d = b_q[0];
                if (s_tick) begin
                    if (s_q == 4'd15) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == 3'd7) state_d = S_STOP;
                        else             n_d = n_q + 3'd1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (s_q == 4'd15) begin
                        state_d      = S_IDLE;
                        tx_done_tick = 1'b1;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
        endcase
    end

    assign tx = tx_q;
endmodule

// File: rtl/uart_stopwatch_host.sv
// Host-side initiator for the UART stopwatch: sends C/G/S/R commands and, on a
// read, parses the "dd.dd" reply into four BCD digits.
module uart_stopwatch_host
    import uart_stopwatch_host_pkg::*;
#(
    parameter int BAUD_DIV      = DEFAULT_BAUD_DIV,
    parameter int TIMEOUT_TICKS = 2048
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_clear,
    input  logic       cmd_go,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       rx,
    output logic       tx,
    output logic       busy,
    output logic       time_valid,
    output logic       err_format,
    output logic       err_timeout,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0
);
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS);

    logic       baud_tick;
    logic       tx_start;
    logic       tx_done_tick;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       byte_ok;

    logic [1:0]    rx_sync_q, rx_sync_d;
    logic [2:0]    state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [11:0]   shadow_q, shadow_d;
    logic [15:0]   digits_q, digits_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          time_valid_q, time_valid_d;
    logic          err_format_q, err_format_d;
    logic          err_timeout_q, err_timeout_d;

    baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk  (clk),
        .reset(reset),
        .tick (baud_tick)
    );

    uart_tx u_tx (
        .clk         (clk),
        .reset       (reset),
        .tx_start    (tx_start),
        .s_tick      (baud_tick),
        .din         (cmd_q),
        .tx_done_tick(tx_done_tick),
        .tx          (tx)
    );

    // rx comes from another board, so it is synchronised before the receiver sees it.
    uart_rx u_rx (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx_sync_q[1]),
        .s_tick      (baud_tick),
        .rx_done_tick(rx_done_tick),
        .dout        (rx_data)
    );

    assign tx_start = (state_q == ST_SEND_CMD);

    always_comb begin
        rx_sync_d     = {rx_sync_q[0], rx};
        state_d       = state_q;
        cmd_d         = cmd_q;
        shadow_d      = shadow_q;
        digits_d      = digits_q;
        to_cnt_d      = to_cnt_q;
        time_valid_d  = 1'b0;
        err_format_d  = 1'b0;
        err_timeout_d = 1'b0;
        byte_ok       = (state_q == ST_RX_DOT) ? (rx_data == ASCII_DOT) : is_digit(rx_data);
        case (state_q)
            ST_IDLE: begin
                if (cmd_clear | cmd_stop | cmd_go | cmd_read) begin
                    state_d = ST_SEND_CMD;
                    if (cmd_clear)     cmd_d = ASCII_CLEAR;
                    else if (cmd_stop) cmd_d = ASCII_STOP;
                    else if (cmd_go)   cmd_d = ASCII_GO;
                    else               cmd_d = ASCII_READ;
                end
            end
            ST_SEND_CMD: begin
                if (tx_done_tick) begin
                    state_d  = (cmd_q == ASCII_READ) ? ST_RX_D3 : ST_IDLE;
                    to_cnt_d = '0;
                end
            end
            ST_RX_D3, ST_RX_D2, ST_RX_DOT, ST_RX_D1, ST_RX_D0: begin
                // A byte completing on the expiry cycle takes precedence over the timeout.
                if (rx_done_tick) begin
                    to_cnt_d = '0;
                    if (!byte_ok) begin
                        err_format_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        case (state_q)
                            ST_RX_D3: begin
                                shadow_d[11:8] = rx_data[3:0];
                                state_d        = ST_RX_D2;
                            end
                            ST_RX_D2: begin
                                shadow_d[7:4] = rx_data[3:0];
                                state_d       = ST_RX_DOT;
                            end
                            ST_RX_DOT: state_d = ST_RX_D1;
                            ST_RX_D1: begin
                                shadow_d[3:0] = rx_data[3:0];
                                state_d       = ST_RX_D0;
                            end
                            default: begin
                                digits_d     = {shadow_q, rx_data[3:0]};
                                time_valid_d = 1'b1;
                                state_d      = ST_IDLE;
                            end
                        endcase
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else if (baud_tick) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_q     <= 2'b11;
            state_q       <= ST_IDLE;
            cmd_q         <= '0;
            shadow_q      <= '0;
            digits_q      <= '0;
            to_cnt_q      <= '0;
            time_valid_q  <= 1'b0;
            err_format_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            rx_sync_q     <= rx_sync_d;
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            shadow_q      <= shadow_d;
            digits_q      <= digits_d;
            to_cnt_q      <= to_cnt_d;
            time_valid_q  <= time_valid_d;
            err_format_q  <= err_format_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign busy             = (state_q != ST_IDLE);
    assign time_valid       = time_valid_q;
    assign err_format       = err_format_q;
    assign err_timeout      = err_timeout_q;
    assign {d3, d2, d1, d0} = digits_q;
endmodule
